sd_sector_buf: RTL and testbench

- Downstream consumer of the SD sector reader.
- Issues one-sector read requests (rd_en) only when its internal FIFO can hold a whole sector.
- Captures the 16-bit words strobed by rd_data_en and presents them to the next stage (frame/SDRAM writer) on a valid/ready stream.
- Tracks completed sectors and flags short/long sectors, request timeouts and overflow.

---
 rtl/sd_sector_buf.sv | 210 +++++++++++++++++++++
 tb/tb_sd_sector_buf.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_sector_buf.sv
// sd_sector_buf
//   Consumer of the SD sector reader. Requests one sector at a time (rd_en)
//   only when the FIFO has room for a whole sector, captures the strobed
//   words into a first-word-fall-through FIFO and streams them out on a
//   valid/ready interface. Counts good sectors and flags sector faults.
//
// Build option:
//   SD_BUF_BYTE_SWAP_EN  when defined, each word is stored byte-swapped
//                        ({rd_data[7:0], rd_data[15:8]}); otherwise unchanged.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   enable          allow new sector requests
//   flush           one-cycle pulse: clears FIFO and sticky flags
//   init_end        card initialised; no request while low
//   rd_busy         reader busy
//   rd_data_en      input word strobe
//   rd_data         input word
//   rd_en           one-cycle sector request pulse
//   out_valid       out_data holds a valid word
//   out_data        head of FIFO
//   out_ready       downstream accepts the word
//   fifo_level      current occupancy
//   sector_cnt      completed good sectors (wraps)
//   sector_err      sticky: short/long sector, stray word or request timeout
//   overflow        sticky: word arrived while FIFO full
module sd_sector_buf #(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned SECTOR_WORDS = 256,
    parameter int unsigned FIFO_DEPTH   = 1024,
    parameter int unsigned BUSY_TIMEOUT = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          flush,
    input  logic                          init_end,
    input  logic                          rd_busy,
    input  logic                          rd_data_en,
    input  logic [DATA_W-1:0]             rd_data,
    output logic                          rd_en,
    output logic                          out_valid,
    output logic [DATA_W-1:0]             out_data,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   sector_cnt,
    output logic                          sector_err,
    output logic                          overflow
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned WW = $clog2(SECTOR_WORDS + 2);
    localparam int unsigned TW = $clog2(BUSY_TIMEOUT + 1);

    localparam logic [LW-1:0] LVL_FULL    = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] LVL_REQ_MAX = LW'(FIFO_DEPTH - SECTOR_WORDS);
    localparam logic [WW-1:0] WC_FULL     = WW'(SECTOR_WORDS);
    localparam logic [WW-1:0] WC_SAT      = WW'(SECTOR_WORDS + 1);
    localparam logic [TW-1:0] TO_LAST     = TW'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        RECV,
        DRAIN
    } state_t;

    state_t state, state_d;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [WW-1:0]     word_cnt, word_cnt_next;
    logic [TW-1:0]     to_cnt;
    logic [DATA_W-1:0] wr_word;
    logic              full, pop, accept, push, drop;
    logic              req, good_sector, bad_event;

`ifdef SD_BUF_BYTE_SWAP_EN
    assign wr_word = {rd_data[7:0], rd_data[DATA_W-1:8]};
`else
    assign wr_word = rd_data;
`endif

    assign full      = (fifo_level == LVL_FULL);
    assign out_valid = (fifo_level != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    // Flush dominates both sides of the FIFO; DRAIN discards reader words.
    assign pop    = out_valid & out_ready & ~flush;
    assign accept = rd_data_en & (state != DRAIN) & ~flush;
    assign push   = accept & (~full | pop);
    assign drop   = accept & full & ~pop;

    // Includes a word strobed on the same cycle rd_busy falls.
    assign word_cnt_next = (rd_data_en && word_cnt != WC_SAT) ? word_cnt + 1'b1 : word_cnt;

    always_comb begin
        state_d     = state;
        req         = 1'b0;
        good_sector = 1'b0;
        bad_event   = 1'b0;
        case (state)
            IDLE: begin
                if (!flush) begin
                    if (rd_data_en)
                        bad_event = 1'b1;
                    if (enable && init_end && !rd_busy && fifo_level <= LVL_REQ_MAX) begin
                        req     = 1'b1;
                        state_d = WAIT_BUSY;
                    end
                end
            end
            WAIT_BUSY: begin
                if (flush) begin
                    state_d = DRAIN;
                end else begin
                    if (rd_data_en)
                        bad_event = 1'b1;
                    if (rd_busy) begin
                        state_d = RECV;
                    end else if (to_cnt == TO_LAST) begin
                        bad_event = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            RECV: begin
                if (flush) begin
                    state_d = DRAIN;
                end else if (!rd_busy) begin
                    state_d = IDLE;
                    if (word_cnt_next == WC_FULL)
                        good_sector = 1'b1;
                    else
                        bad_event = 1'b1;
                end
            end
            DRAIN: begin
                if (!rd_busy)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_en      <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            word_cnt   <= '0;
            to_cnt     <= '0;
            sector_cnt <= '0;
            sector_err <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            rd_en <= req;

            if (req)
                to_cnt <= '0;
            else if (state == WAIT_BUSY)
                to_cnt <= to_cnt + 1'b1;

            if (req)
                word_cnt <= '0;
            else if (state == RECV)
                word_cnt <= word_cnt_next;

            if (good_sector)
                sector_cnt <= sector_cnt + 1'b1;

            if (flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_level <= '0;
                sector_err <= 1'b0;
                overflow   <= 1'b0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   fifo_level <= fifo_level + 1'b1;
                    2'b01:   fifo_level <= fifo_level - 1'b1;
                    default: ;
                endcase
                if (bad_event)
                    sector_err <= 1'b1;
                if (drop)
                    overflow <= 1'b1;
            end
        end
    end

    // Storage is not reset; out_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_word;
    end

endmodule

// File: tb/tb_sd_sector_buf.sv
module tb_sd_sector_buf;
    localparam int DEPTH = 1024;
    localparam int SW    = 256;

    logic        clk = 1'b0;
    logic        rst_n, enable, flush, init_end, rd_busy, rd_data_en, out_ready;
    logic [15:0] rd_data;
    logic        rd_en, out_valid, overflow, sector_err;
    logic [15:0] out_data, sector_cnt;
    logic [10:0] fifo_level;

    sd_sector_buf #(
        .DATA_W(16), .SECTOR_WORDS(SW), .FIFO_DEPTH(DEPTH), .BUSY_TIMEOUT(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
        .init_end(init_end), .rd_busy(rd_busy), .rd_data_en(rd_data_en),
        .rd_data(rd_data), .rd_en(rd_en), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .fifo_level(fifo_level),
        .sector_cnt(sector_cnt), .sector_err(sector_err), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Reference model: expected FIFO contents as a queue plus flag/counter state.
    logic [15:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          rdy_mode = 0;   // 0: ready low, 1: ready high, 2: random
    int          req_cnt = 0;
    int          req_lvl = 0;
    bit          saw_req = 0;
    bit          prev_rd_en = 0;
    bit          m_ovf = 0;
    bit          m_err = 0;
    int          m_sec = 0;

    function automatic logic [15:0] exp_word(input logic [15:0] w);
`ifdef SD_BUF_BYTE_SWAP_EN
        return {w[7:0], w[15:8]};
`else
        return w;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive ready, advance, update the model, check the stream.
    task automatic tick(input bit acc);
        bit pop;
        if (rdy_mode == 2) out_ready = 1'($urandom_range(0, 1));
        else               out_ready = (rdy_mode == 1);
        pop = (exp_q.size() != 0) && out_ready;
        @(posedge clk);
        if (flush) begin
            exp_q.delete();
            m_err = 0;
            m_ovf = 0;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (rd_data_en && acc) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(exp_word(rd_data));
                else m_ovf = 1;
            end
        end
        #1;
        chk("out_valid", out_valid, exp_q.size() != 0);
        chk("fifo_level", fifo_level, exp_q.size());
        chk("overflow", overflow, m_ovf);
        if (exp_q.size() != 0) chk("out_data", out_data, exp_q[0]);
        if (rd_en === 1'b1) begin
            chk("rd_en_width", prev_rd_en, 0);
            req_cnt++;
            saw_req = 1;
            req_lvl = int'(fifo_level);
        end
        prev_rd_en = (rd_en === 1'b1);
    endtask

    task automatic wait_req();
        int n = 0;
        while (!saw_req && n < 3000) begin
            tick(0);
            n++;
        end
        chk("rd_en_seen", saw_req, 1);
        saw_req = 0;
    endtask

    // Reader model: answers a request with nwords words, dropping rd_busy
    // together with the last word; optional flush at word flush_at.
    task automatic serve(input int nwords, input int flush_at, input bit rnd);
        bit draining = 0;
        saw_req = 0;
        rd_busy = 1;
        tick(0);
        for (int i = 0; i < nwords; i++) begin
            if (rnd) repeat ($urandom_range(0, 2)) tick(0);
            rd_data_en = 1;
            rd_data    = rnd ? 16'($urandom) : 16'(i);
            if (i == flush_at) flush = 1;
            if (i == nwords - 1) rd_busy = 0;
            tick(!draining);
            if (flush) begin
                flush = 0;
                draining = 1;
                chk("level_after_flush", fifo_level, 0);
            end
            rd_data_en = 0;
        end
        rd_busy = 0;
        tick(0);
        tick(0);
        if (!draining) begin
            if (nwords == SW) m_sec++;
            else m_err = 1;
        end
        chk("sector_cnt", sector_cnt, m_sec);
        chk("sector_err", sector_err, m_err);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_n = 0; enable = 0; flush = 0; init_end = 0; rd_busy = 0;
        rd_data_en = 0; rd_data = '0; out_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_en", rd_en, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_sector_cnt", sector_cnt, 0);
        chk("rst_sector_err", sector_err, 0);
        chk("rst_overflow", overflow, 0);
        rst_n = 1;

        // Enabled but card not initialised: no request.
        enable = 1;
        repeat (5) tick(0);
        chk("no_req_before_init", req_cnt, 0);

        // Single sector 0x0000..0x00FF, streamed straight out.
        init_end = 1; rdy_mode = 1;
        wait_req();
        enable = 0;
        serve(SW, -1, 0);
        repeat (3) tick(0);
        chk("one_req_per_sector", req_cnt, 1);

        // Stray word in IDLE: stored (byte order per build) and flagged.
        rdy_mode = 0;
        rd_data_en = 1; rd_data = 16'h1234;
        tick(1);
        rd_data_en = 0;
        m_err = 1;
`ifdef SD_BUF_BYTE_SWAP_EN
        chk("byte_order", out_data, 16'h3412);
`else
        chk("byte_order", out_data, 16'h1234);
`endif
        chk("stray_err", sector_err, 1);
        flush = 1; tick(0); flush = 0;
        chk("flush_clears_err", sector_err, 0);

        // Ready low: exactly four sectors fill the FIFO.
        base = req_cnt;
        enable = 1;
        for (int k = 0; k < 4; k++) begin
            wait_req();
            serve(SW, -1, 1);
        end
        repeat (40) tick(0);
        chk("four_sectors", req_cnt - base, 4);
        chk("level_full", fifo_level, DEPTH);

        // Push and pop together at full, then a push at full without pop.
        rdy_mode = 1; rd_data_en = 1; rd_data = 16'hBEEF;
        tick(1);
        rdy_mode = 0; rd_data = 16'hCAFE;
        tick(1);
        rd_data_en = 0;
        m_err = 1;
        tick(0);
        chk("ovf_set", overflow, 1);
        chk("level_still_full", fifo_level, DEPTH);
        chk("fifth_blocked", req_cnt - base, 4);

        // Draining reopens space: fifth request at the 768 threshold.
        rdy_mode = 1;
        wait_req();
        enable = 0;
        chk("fifth_req_level", req_lvl, DEPTH - SW - 1);
        rdy_mode = 2;
        serve(SW, -1, 1);

        // Flush in IDLE clears flags, blocks the request that cycle only.
        enable = 1; flush = 1;
        tick(0);
        flush = 0;
        chk("no_req_on_flush", rd_en, 0);
        chk("flush_err", sector_err, 0);
        chk("flush_ovf", overflow, 0);
        chk("flush_keeps_cnt", sector_cnt, m_sec);
        tick(0);
        chk("req_after_flush", rd_en, 1);
        enable = 0;
        serve(SW - 1, -1, 1);     // short sector
        enable = 1;
        wait_req();
        enable = 0;
        serve(SW, -1, 1);         // next sector still good

        // Request timeout.
        flush = 1; tick(0); flush = 0;
        enable = 1;
        wait_req();
        repeat (15) tick(0);
        chk("err_before_timeout", sector_err, 0);
        tick(0);
        m_err = 1;
        chk("err_timeout", sector_err, 1);
        tick(0);
        chk("req_after_timeout", rd_en, 1);
        enable = 0;
        serve(SW, -1, 1);

        // Flush at word 100: rest of sector discarded.
        flush = 1; tick(0); flush = 0;
        enable = 1;
        wait_req();
        enable = 0;
        rdy_mode = 0;
        base = req_cnt;
        serve(SW, 100, 0);
        chk("no_req_in_drain", req_cnt, base);

        // Normal sector after the drain.
        rdy_mode = 2; enable = 1;
        wait_req();
        enable = 0;
        serve(SW, -1, 1);
        rdy_mode = 1;
        for (int n = 0; n < 2000 && exp_q.size() != 0; n++) tick(0);
        chk("final_empty", fifo_level, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
